uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver that deserialises 8N1 frames arriving on the Rx serial pin into a parallel byte. It is the receive-side counterpart of the existing UART transmitter and shares its run-time baud-rate interface: BR_Clocks is the number of clk cycles per bit. It sits between the pad and the control wrapper, giving the wrapper a valid/ack byte handshake plus error pulses.

Parameters:
MIN_BR, 4, smallest supported clocks-per-bit; smaller latched BR_Clocks values are clamped to MIN_BR

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
Rx_Serial  input  1  asynchronous serial line, idle high
BR_Clocks  input  15  clk cycles per bit, sampled only in IDLE
Rx_Ack  input  1  wrapper has consumed Rx_Parallel; clears Rx_Valid
Rx_Parallel  output  8  last correctly framed byte
Rx_Valid  output  1  high from byte capture until acked
Rx_Done  output  1  one-cycle pulse per correctly framed byte
Frame_Err  output  1  one-cycle pulse when stop bit samples 0
Overrun_Err  output  1  one-cycle pulse when a byte lands while Rx_Valid=1 and no same-cycle Rx_Ack
Rx_Ready  output  1  high in IDLE; BR_Clocks may be changed safely

Behaviour:
- Reset (rst_n=0 at posedge):
  - Synchroniser flops are set to 1 and the state goes to IDLE.
  - All counters and the shift register go to 0.
  - Rx_Parallel=0; Rx_Valid, Rx_Done, Frame_Err and Overrun_Err are 0; Rx_Ready=1.
  - Reset mid-frame discards the partial byte.
- Input path: a 2-flop synchroniser, 2 cycles latency. All state logic uses only the synchronised bit (rx_s).
- IDLE:
  - Rx_Ready=1. Latch r_BR = max(BR_Clocks, MIN_BR) every cycle. Define HALF = r_BR>>1.
  - rx_s=0 → START, clk_count=0, Rx_Ready=0 on the next cycle.
- START:
  - Increment clk_count.
  - At clk_count==HALF, sample rx_s:
    - 0 → DATA, clk_count=0, bit_idx=0.
    - 1 → glitch; return to IDLE with no outputs.
- DATA:
  - At clk_count==r_BR-1, shift rx_s into bit bit_idx (LSB first) and set clk_count=0. Each sample lands at bit centre.
  - After bit_idx==7 is sampled → STOP. Otherwise increment bit_idx.
- STOP: at clk_count==r_BR-1, sample rx_s.
  - 1: Rx_Parallel<=shift register, Rx_Done=1 for one cycle, Rx_Valid<=1 → IDLE.
    - If Rx_Valid was already 1 and Rx_Ack=0 that cycle, Overrun_Err=1 for one cycle. The new byte overwrites.
  - 0: Frame_Err=1 for one cycle; Rx_Parallel and Rx_Valid are unchanged → BREAK_WAIT.
- BREAK_WAIT: stay until rx_s=1, then → IDLE. This prevents a held-low line from being decoded as repeated 0x00 frames.
- Rx_Valid:
  - Set on a good capture; cleared by Rx_Ack.
  - Capture and Rx_Ack in the same cycle: Rx_Valid stays 1, no overrun.
  - Rx_Ack while Rx_Valid=0: ignored.
- BR_Clocks changes outside IDLE have no effect until the next IDLE.
- Counter widths: clk_count is 15 bits. Compares are against r_BR-1 and HALF, so r_BR=32767 must work without wrap.
- Frame latency:
  - From the synchronised start edge to Rx_Done is HALF + 9*r_BR + 1 cycles, with a tolerance of ±1.
  - Add 2 cycles for the synchroniser relative to the pin.
- Back-to-back frames: the STOP exit at mid-stop-bit leaves half a bit of margin, so a start bit immediately following a stop bit is detected.

Test Plan:
- BR_Clocks=16, send 0xA5 8N1 → Rx_Parallel=0xA5, Rx_Valid=1, single-cycle Rx_Done about 155 cycles after the pin falling edge; Frame_Err=0.
- BR_Clocks=16, pulse Rx_Serial low for 4 cycles only → state returns to IDLE, no Rx_Done/Rx_Valid/Frame_Err, Rx_Ready back to 1.
- Send 0x3C with stop bit 0, then hold the line low 64 cycles → one Frame_Err pulse, Rx_Valid stays 0, no further frames decoded; after the line returns high, 0x5A is received correctly.
- Send 0x11 then 0x22 back-to-back, no Rx_Ack → Overrun_Err pulse at the second Rx_Done, Rx_Parallel=0x22. Repeat with Rx_Ack asserted in the capture cycle → no Overrun_Err, Rx_Valid=1.
- Change BR_Clocks 16→8 mid-frame → current byte decoded at 16. The next frame sent at 8 decodes correctly; BR_Clocks=2 behaves as 4.
- Assert rst_n=0 during bit 3 of a frame → all outputs at reset values next cycle; a subsequent clean frame 0xFF is received.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, centre-sampling FSM, valid/ack byte
// handshake with one-cycle done/framing/overrun pulses. Baud set in clocks per bit.
module uart_rx #(
  parameter int MIN_BR = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Rx_Serial,
  input  logic [14:0] BR_Clocks,
  input  logic        Rx_Ack,
  output logic [7:0]  Rx_Parallel,
  output logic        Rx_Valid,
  output logic        Rx_Done,
  output logic        Frame_Err,
  output logic        Overrun_Err,
  output logic        Rx_Ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_sync1, r_sync2;
  logic [14:0] r_br;
  logic [14:0] r_clk_count;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_parallel;
  logic        r_valid, r_done, r_frame_err, r_overrun, r_ready;

  logic        w_rx_s;
  logic [14:0] w_br_clamped, w_half, w_br_m1;
  logic        w_hit_half, w_hit_bit;
  logic        w_cnt_clr, w_cnt_inc, w_bit_start, w_shift_en, w_good_stop, w_bad_stop;

  assign w_rx_s       = r_sync2;
  assign w_br_clamped = (BR_Clocks < 15'(MIN_BR)) ? 15'(MIN_BR) : BR_Clocks;
  assign w_half       = {1'b0, r_br[14:1]};
  assign w_br_m1      = r_br - 15'd1;
  assign w_hit_half   = (r_clk_count == w_half);
  assign w_hit_bit    = (r_clk_count == w_br_m1);

  // Two-flop synchroniser on the asynchronous serial pin; idles high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= Rx_Serial;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_bit_start  = 1'b0;
    w_shift_en   = 1'b0;
    w_good_stop  = 1'b0;
    w_bad_stop   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rx_s) w_next_state = S_START;
        else         w_next_state = S_IDLE;
      end
      S_START: begin
        if (w_hit_half) begin
          w_cnt_clr = 1'b1;
          if (!w_rx_s) begin
            w_next_state = S_DATA;
            w_bit_start  = 1'b1;
          end else begin
            w_next_state = S_IDLE;
          end
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DATA: begin
        if (w_hit_bit) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_idx == 3'd7) w_next_state = S_STOP;
          else                   w_next_state = S_DATA;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_STOP: begin
        if (w_hit_bit) begin
          w_cnt_clr = 1'b1;
          if (w_rx_s) begin
            w_good_stop  = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_bad_stop   = 1'b1;
            w_next_state = S_BREAK;
          end
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      // A held-low line must not be decoded as a stream of 0x00 frames.
      S_BREAK: begin
        w_cnt_clr = 1'b1;
        if (w_rx_s) w_next_state = S_IDLE;
        else        w_next_state = S_BREAK;
      end
      default: begin
        w_cnt_clr    = 1'b1;
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Bit timing counters, baud latch and shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_br        <= 15'(MIN_BR);
      r_clk_count <= 15'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
    end else begin
      if (r_state == S_IDLE) r_br <= w_br_clamped;
      else                   r_br <= r_br;
      if (w_cnt_clr)      r_clk_count <= 15'd0;
      else if (w_cnt_inc) r_clk_count <= r_clk_count + 15'd1;
      else                r_clk_count <= r_clk_count;
      if (w_bit_start)                          r_bit_idx <= 3'd0;
      else if (w_shift_en && r_bit_idx != 3'd7) r_bit_idx <= r_bit_idx + 3'd1;
      else                                      r_bit_idx <= r_bit_idx;
      if (w_shift_en) r_shift[r_bit_idx] <= w_rx_s;
    end
  end

  // Registered byte handshake and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_parallel  <= 8'd0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_done      <= w_good_stop;
      r_frame_err <= w_bad_stop;
      r_overrun   <= w_good_stop & r_valid & ~Rx_Ack;
      r_ready     <= (w_next_state == S_IDLE);
      if (w_good_stop) r_parallel <= r_shift;
      else             r_parallel <= r_parallel;
      // A capture coinciding with an ack keeps the new byte valid.
      if (w_good_stop) r_valid <= 1'b1;
      else if (Rx_Ack) r_valid <= 1'b0;
      else             r_valid <= r_valid;
    end
  end

  assign Rx_Parallel = r_parallel;
  assign Rx_Valid    = r_valid;
  assign Rx_Done     = r_done;
  assign Frame_Err   = r_frame_err;
  assign Overrun_Err = r_overrun;
  assign Rx_Ready    = r_ready;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: one task per scenario, pulse
// counters from a negedge monitor, hand-computed expected bytes and latencies.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Rx_Serial;
  logic [14:0] BR_Clocks;
  logic        Rx_Ack;
  logic [7:0]  Rx_Parallel;
  logic        Rx_Valid, Rx_Done, Frame_Err, Overrun_Err, Rx_Ready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int done_cnt = 0, ferr_cnt = 0, ovr_cnt = 0;
  int done_cyc = 0, ovr_cyc = 0;

  uart_rx #(.MIN_BR(4)) dut (
    .clk(clk), .rst_n(rst_n), .Rx_Serial(Rx_Serial), .BR_Clocks(BR_Clocks),
    .Rx_Ack(Rx_Ack), .Rx_Parallel(Rx_Parallel), .Rx_Valid(Rx_Valid),
    .Rx_Done(Rx_Done), .Frame_Err(Frame_Err), .Overrun_Err(Overrun_Err),
    .Rx_Ready(Rx_Ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts high cycles of each strobe and remembers when.
  always @(negedge clk) begin
    if (Rx_Done === 1'b1) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (Frame_Err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (Overrun_Err === 1'b1) begin ovr_cnt <= ovr_cnt + 1; ovr_cyc <= cyc; end
  end

  task automatic drive_bit(input logic b, input int n);
    Rx_Serial = b;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int br);
    drive_bit(1'b0, br);
    for (int i = 0; i < 8; i++) drive_bit(d[i], br);
    drive_bit(stop_b, br);
  endtask

  task automatic pulse_ack();
    Rx_Ack = 1'b1;
    @(posedge clk); #1;
    Rx_Ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Rx_Serial = 1'b1; Rx_Ack = 1'b0; BR_Clocks = 15'd16;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({Rx_Parallel, Rx_Valid, Rx_Done, Frame_Err, Overrun_Err, Rx_Ready} !== 13'h001) begin
      n_fail++;
      $display("FAIL reset_outputs: got par=%h v=%b d=%b fe=%b ov=%b rdy=%b, want par=00 v=0 d=0 fe=0 ov=0 rdy=1",
               Rx_Parallel, Rx_Valid, Rx_Done, Frame_Err, Overrun_Err, Rx_Ready);
    end
    rst_n = 1'b1;
    drive_bit(1'b1, 8);
  endtask

  task automatic test_basic();
    int d0, f0, start, lat;
    d0 = done_cnt; f0 = ferr_cnt; start = cyc;
    send_frame(8'hA5, 1'b1, 16);
    drive_bit(1'b1, 16);
    lat = done_cyc - start;
    n_tests++;
    if (Rx_Parallel !== 8'hA5) begin n_fail++; $display("FAIL basic_byte: got %h want a5", Rx_Parallel); end
    n_tests++;
    if (Rx_Valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", Rx_Valid); end
    n_tests++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_cycles: got %0d want 1", done_cnt - d0); end
    n_tests++;
    if (ferr_cnt - f0 != 0) begin n_fail++; $display("FAIL basic_frame_err: got %0d want 0", ferr_cnt - f0); end
    n_tests++;
    if (lat < 154 || lat > 157) begin n_fail++; $display("FAIL basic_latency: got %0d want 154..157", lat); end
    n_tests++;
    if (Rx_Ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", Rx_Ready); end
  endtask

  task automatic test_ack();
    pulse_ack();
    n_tests++;
    if (Rx_Valid !== 1'b0) begin n_fail++; $display("FAIL ack_clears: got %b want 0", Rx_Valid); end
    pulse_ack();
    n_tests++;
    if (Rx_Valid !== 1'b0 || Rx_Parallel !== 8'hA5) begin
      n_fail++; $display("FAIL ack_idle: got v=%b par=%h want v=0 par=a5", Rx_Valid, Rx_Parallel);
    end
  endtask

  task automatic test_glitch();
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 1);
    n_tests++;
    if (Rx_Ready !== 1'b0) begin n_fail++; $display("FAIL glitch_start_seen: got rdy=%b want 0", Rx_Ready); end
    drive_bit(1'b1, 40);
    n_tests++;
    if (done_cnt != d0 || ferr_cnt != f0 || Rx_Valid !== 1'b0) begin
      n_fail++; $display("FAIL glitch_no_output: got done=%0d ferr=%0d v=%b want 0 0 0", done_cnt - d0, ferr_cnt - f0, Rx_Valid);
    end
    n_tests++;
    if (Rx_Ready !== 1'b1) begin n_fail++; $display("FAIL glitch_ready: got %b want 1", Rx_Ready); end
  endtask

  task automatic test_frame_err();
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 16);
    drive_bit(1'b0, 64);
    n_tests++;
    if (Rx_Ready !== 1'b0) begin n_fail++; $display("FAIL break_hold: got rdy=%b want 0", Rx_Ready); end
    drive_bit(1'b1, 32);
    n_tests++;
    if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL frame_err_pulse: got %0d want 1", ferr_cnt - f0); end
    n_tests++;
    if (done_cnt != d0 || Rx_Valid !== 1'b0 || Rx_Parallel !== 8'hA5) begin
      n_fail++; $display("FAIL frame_err_no_byte: got done=%0d v=%b par=%h want 0 0 a5", done_cnt - d0, Rx_Valid, Rx_Parallel);
    end
    send_frame(8'h5A, 1'b1, 16);
    drive_bit(1'b1, 16);
    n_tests++;
    if (Rx_Parallel !== 8'h5A || done_cnt - d0 != 1 || ferr_cnt - f0 != 1) begin
      n_fail++; $display("FAIL after_break: got par=%h done=%0d ferr=%0d want 5a 1 1", Rx_Parallel, done_cnt - d0, ferr_cnt - f0);
    end
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    int d0, o0;
    d0 = done_cnt; o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 16);
    send_frame(8'h22, 1'b1, 16);
    drive_bit(1'b1, 16);
    n_tests++;
    if (done_cnt - d0 != 2 || Rx_Parallel !== 8'h22) begin
      n_fail++; $display("FAIL b2b_bytes: got done=%0d par=%h want 2 22", done_cnt - d0, Rx_Parallel);
    end
    n_tests++;
    if (ovr_cnt - o0 != 1 || ovr_cyc != done_cyc) begin
      n_fail++; $display("FAIL b2b_overrun: got ovr=%0d at %0d done at %0d want 1 at same cycle", ovr_cnt - o0, ovr_cyc, done_cyc);
    end
    pulse_ack();
    d0 = done_cnt; o0 = ovr_cnt;
    fork
      begin
        send_frame(8'h11, 1'b1, 16);
        send_frame(8'h22, 1'b1, 16);
      end
      begin
        repeat (315) @(posedge clk);
        #1 Rx_Ack = 1'b1;
        @(posedge clk);
        #1 Rx_Ack = 1'b0;
      end
    join
    drive_bit(1'b1, 16);
    n_tests++;
    if (ovr_cnt != o0 || done_cnt - d0 != 2) begin
      n_fail++; $display("FAIL ack_same_cycle_overrun: got ovr=%0d done=%0d want 0 2", ovr_cnt - o0, done_cnt - d0);
    end
    n_tests++;
    if (Rx_Valid !== 1'b1 || Rx_Parallel !== 8'h22) begin
      n_fail++; $display("FAIL ack_same_cycle_valid: got v=%b par=%h want 1 22", Rx_Valid, Rx_Parallel);
    end
    pulse_ack();
  endtask

  task automatic test_baud_change();
    fork
      send_frame(8'h96, 1'b1, 16);
      begin
        repeat (40) @(posedge clk);
        #1 BR_Clocks = 15'd8;
      end
    join
    drive_bit(1'b1, 16);
    n_tests++;
    if (Rx_Parallel !== 8'h96) begin n_fail++; $display("FAIL baud_mid_frame: got %h want 96", Rx_Parallel); end
    send_frame(8'hC3, 1'b1, 8);
    drive_bit(1'b1, 16);
    n_tests++;
    if (Rx_Parallel !== 8'hC3) begin n_fail++; $display("FAIL baud_8: got %h want c3", Rx_Parallel); end
    BR_Clocks = 15'd2;
    drive_bit(1'b1, 8);
    send_frame(8'h69, 1'b1, 4);
    drive_bit(1'b1, 16);
    n_tests++;
    if (Rx_Parallel !== 8'h69 || Rx_Valid !== 1'b1) begin
      n_fail++; $display("FAIL baud_clamp: got par=%h v=%b want 69 1", Rx_Parallel, Rx_Valid);
    end
    BR_Clocks = 15'd16;
    drive_bit(1'b1, 8);
  endtask

  task automatic test_reset_mid_frame();
    int d0, f0;
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b1, 8);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({Rx_Parallel, Rx_Valid, Rx_Done, Frame_Err, Overrun_Err, Rx_Ready} !== 13'h001) begin
      n_fail++;
      $display("FAIL reset_mid_frame: got par=%h v=%b d=%b fe=%b ov=%b rdy=%b, want par=00 v=0 d=0 fe=0 ov=0 rdy=1",
               Rx_Parallel, Rx_Valid, Rx_Done, Frame_Err, Overrun_Err, Rx_Ready);
    end
    rst_n = 1'b1;
    d0 = done_cnt; f0 = ferr_cnt;
    drive_bit(1'b1, 104);
    n_tests++;
    if (done_cnt != d0 || ferr_cnt != f0) begin
      n_fail++; $display("FAIL reset_discard: got done=%0d ferr=%0d want 0 0", done_cnt - d0, ferr_cnt - f0);
    end
    send_frame(8'hFF, 1'b1, 16);
    drive_bit(1'b1, 16);
    n_tests++;
    if (Rx_Parallel !== 8'hFF || Rx_Valid !== 1'b1 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL after_reset_ff: got par=%h v=%b done=%0d want ff 1 1", Rx_Parallel, Rx_Valid, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_baud_change();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
